// File: rtl/root_result_fifo.sv
// Collection FIFO for square-root results: captures a root on each rising edge of
// the pipeline ready flag and hands it to a consumer through a valid/ack handshake.
module root_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W-1:0]             root_i,
    input  logic                     root_ready_i,
    input  logic                     ack_i,
    input  logic                     clr_ovf_i,
    output logic [W-1:0]             root_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_readyQ;
    logic          r_overflow;

    logic w_push;
    logic w_pop;
    logic w_pushAcc;
    logic w_drop;
    logic w_full;
    logic w_valid;

    // Status flags come only from the count register, so no input reaches an output.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_valid   = (r_count != '0);

    assign w_push    = root_ready_i & ~r_readyQ;
    assign w_pop     = w_valid & ack_i;
    assign w_pushAcc = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_readyQ   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_readyQ <= root_ready_i;
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_pushAcc && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_pushAcc) begin
                r_count <= r_count - CW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset; stale entries are masked by root_o when empty.
    always_ff @(posedge clk) begin
        if (rst_n && w_pushAcc) begin
            r_mem[r_wrPtr] <= root_i;
        end
    end

    assign root_o     = w_valid ? r_mem[r_rdPtr] : '0;
    assign valid_o    = w_valid;
    assign count_o    = r_count;
    assign full_o     = w_full;
    assign empty_o    = ~w_valid;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_root_result_fifo.sv
// Directed bench for root_result_fifo; a queue of expected roots is filled as
// pulses are driven and drained as the consumer acknowledges entries.
module tb_root_result_fifo;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  root_i;
    logic          root_ready_i;
    logic          ack_i;
    logic          clr_ovf_i;
    logic [W-1:0]  root_o;
    logic          valid_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  expQ[$];
    logic          expOvf = 1'b0;

    root_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .root_i       (root_i),
        .root_ready_i (root_ready_i),
        .ack_i        (ack_i),
        .clr_ovf_i    (clr_ovf_i),
        .root_o       (root_o),
        .valid_o      (valid_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic checkState(input string tag);
        logic [31:0] expRoot;
        expRoot = (expQ.size() != 0) ? 32'(expQ[0]) : 32'd0;
        checkOutput({tag, ".count"}, 32'(count_o), 32'(expQ.size()));
        checkOutput({tag, ".valid"}, 32'(valid_o), 32'(expQ.size() != 0));
        checkOutput({tag, ".empty"}, 32'(empty_o), 32'(expQ.size() == 0));
        checkOutput({tag, ".full"},  32'(full_o),  32'(expQ.size() == DEPTH));
        checkOutput({tag, ".root"},  32'(root_o),  expRoot);
        checkOutput({tag, ".ovf"},   32'(overflow_o), 32'(expOvf));
    endtask

    // One-cycle ready pulse; the model stores it only if there is room.
    task automatic applyStimulus(input logic [W-1:0] value);
        root_i       = value;
        root_ready_i = 1'b1;
        if (expQ.size() < DEPTH) expQ.push_back(value);
        else                     expOvf = 1'b1;
        step();
        root_ready_i = 1'b0;
        step();
    endtask

    task automatic popCheck(input string tag);
        checkOutput({tag, ".valid"}, 32'(valid_o), 32'd1);
        if (expQ.size() == 0) begin
            checkOutput({tag, ".model_empty"}, 32'd1, 32'd0);
        end else begin
            checkOutput({tag, ".head"}, 32'(root_o), 32'(expQ[0]));
            void'(expQ.pop_front());
        end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        root_i       = '0;
        root_ready_i = 1'b0;
        ack_i        = 1'b0;
        clr_ovf_i    = 1'b0;
        @(negedge clk);
        step();
        step();
        checkState("reset");

        // Held-high ready yields a single capture.
        rst_n = 1'b1;
        step();
        root_i       = 8'h0C;
        root_ready_i = 1'b1;
        expQ.push_back(8'h0C);
        step();
        checkState("single.first");
        for (int i = 0; i < 4; i++) step();
        checkState("single.held");
        root_ready_i = 1'b0;
        step();
        popCheck("single.pop");
        checkState("single.after");

        // Ack while empty must be ignored.
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        checkState("ack_empty");

        // Fill, overflow, drain, clear.
        for (int v = 1; v <= 4; v++) applyStimulus(W'(v));
        checkState("fill.full");
        applyStimulus(8'd5);
        checkState("fill.ovf");
        for (int v = 1; v <= 4; v++) popCheck("fill.drain");
        checkState("fill.drained");
        clr_ovf_i = 1'b1;
        expOvf    = 1'b0;
        step();
        clr_ovf_i = 1'b0;
        checkState("fill.clr");

        // Push into a full FIFO alongside an ack: no drop.
        for (int v = 1; v <= 4; v++) applyStimulus(W'(v));
        checkOutput("pp.head", 32'(root_o), 32'd1);
        void'(expQ.pop_front());
        expQ.push_back(8'h09);
        root_i       = 8'h09;
        root_ready_i = 1'b1;
        ack_i        = 1'b1;
        step();
        root_ready_i = 1'b0;
        ack_i        = 1'b0;
        step();
        checkState("pp.after");
        for (int i = 0; i < 4; i++) popCheck("pp.drain");
        checkState("pp.drained");

        // Pointers wrap repeatedly.
        applyStimulus(8'h10);
        for (int v = 8'h11; v <= 8'h19; v++) begin
            applyStimulus(W'(v));
            popCheck("wrap.pop");
        end
        popCheck("wrap.last");
        checkState("wrap.end");

        // Drop and clear in the same cycle: the drop wins.
        for (int v = 8'h21; v <= 8'h24; v++) applyStimulus(W'(v));
        root_i       = 8'h25;
        root_ready_i = 1'b1;
        clr_ovf_i    = 1'b1;
        expOvf       = 1'b1;
        step();
        root_ready_i = 1'b0;
        clr_ovf_i    = 1'b0;
        checkState("ovf_vs_clr");
        popCheck("mid.pop");
        checkState("mid.three");

        // Reset mid-operation; ready held high across release counts as a push.
        rst_n        = 1'b0;
        root_i       = 8'h33;
        root_ready_i = 1'b1;
        expQ.delete();
        expOvf = 1'b0;
        step();
        checkState("mid.reset");
        rst_n = 1'b1;
        expQ.push_back(8'h33);
        step();
        checkState("post_reset_push");
        root_ready_i = 1'b0;
        step();
        checkState("post_reset_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
